prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter FRAME_W, default 12: serial frame length in bits, without the parity bit.
REQ-002 Parameter DATA_W, default 8: cache word width; FRAME_W = DATA_W + 4.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 csi_n  in  1  instruction-cache chip select, active low.
REQ-006 csd_n  in  1  data-cache chip select, active low.
REQ-007 mosi  in  1  serial data, sampled on posedge clk.
REQ-008 proc_en_in  in  1  master request to run the processor.
REQ-009 wr_data_out  out  DATA_W  cache write data.
REQ-010 wr_addr_out  out  4  cache write address.
REQ-011 icache_wen_out  out  1  one-cycle icache write strobe.
REQ-012 dcache_wen_out  out  1  one-cycle dcache write strobe.
REQ-013 run_out  out  1  processor enable; low holds the PC in reset.
REQ-014 busy_out  out  1  high in SHIFT or COMMIT.
REQ-015 frame_err_out  out  1  one-cycle pulse when a frame is aborted or rejected.

Function
REQ-016 FSM states: IDLE, SHIFT, COMMIT, RUN.
REQ-017 IDLE->SHIFT when exactly one of csi_n/csd_n is low and proc_en_in is low; that cycle's mosi is captured as bit 0 and the target (I or D) is latched.
REQ-018 IDLE->RUN when proc_en_in is high and both selects are high; proc_en_in has priority over a select asserted in the same cycle.
REQ-019 Both selects low in IDLE: stay in IDLE and pulse frame_err_out.
REQ-020 SHIFT: each cycle shift mosi in LSB-first; a 4-bit counter counts captured bits.
REQ-021 When the counter reaches FRAME_W bits: go to COMMIT; frame[3:0] is the address and frame[FRAME_W-1:4] is the data.
REQ-022 The latched select rising before the frame completes: abort to IDLE, pulse frame_err_out, no write.
REQ-023 proc_en_in is ignored in SHIFT and COMMIT.
REQ-024 COMMIT lasts exactly one cycle and asserts icache_wen_out or dcache_wen_out for the latched target, then returns to IDLE.
REQ-025 Latency: the write strobe is high in the cycle after the last frame bit is sampled.
REQ-026 wr_data_out/wr_addr_out hold the last committed frame until the next commit.
REQ-027 RUN: run_out high; RUN->IDLE when proc_en_in falls; any select low in RUN is ignored.
REQ-028 The counter wraps to 0 on every entry to SHIFT; no partial frame persists across frames.

Reset
REQ-029 rst high for one cycle: state IDLE, counter 0, all strobes 0, run_out 0, busy_out 0, wr_data_out 0, wr_addr_out 0.
REQ-030 rst mid-frame or mid-RUN discards the frame silently: no frame_err_out, no write.

Configuration
REQ-031 Macro PROG_LOADER_PARITY_EN.
REQ-032 Defined: the frame is FRAME_W+1 bits; the last bit is odd parity over the frame; a mismatch goes to IDLE with a frame_err_out pulse and no write.
REQ-033 Undefined: the frame is FRAME_W bits with no parity check; the parity logic is absent.

Structure
REQ-034 Package prog_loader_pkg holds the state enum, FRAME_W, DATA_W, ADDR_W=4 and the target enum (TGT_I, TGT_D).
REQ-035 Sub-module loader_shifter holds the serial-in/parallel-out register and the bit counter; the FSM lives in prog_loader.

Verification
REQ-036 csi_n low for 12 cycles, bits form data 0xA5, addr 0x3 -> icache_wen_out pulses once in cycle 13; wr_data_out=0xA5, wr_addr_out=0x3.
REQ-037 csd_n low, frame data 0xFF, addr 0xE -> dcache_wen_out pulses once; icache_wen_out stays 0.
REQ-038 csi_n rises after 7 bits -> frame_err_out pulses once; no write; the next full frame commits correctly.
REQ-039 proc_en_in high in IDLE -> run_out high next cycle; csi_n low in RUN has no effect; proc_en_in low -> run_out low next cycle.
REQ-040 rst asserted on bit 9 -> all outputs 0 the next cycle; no strobe and no frame_err_out.
REQ-041 With PROG_LOADER_PARITY_EN defined: a 13-bit frame with a bad parity bit -> frame_err_out pulse, no write; a good-parity frame -> write.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and default geometry for the serial program loader.
package prog_loader_pkg;

  localparam int FRAME_W = 12;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT,
    ST_RUN
  } state_t;

  typedef enum logic {
    TGT_I,
    TGT_D
  } target_t;

endpackage

// File: rtl/loader_shifter.sv
// LSB-first serial-in/parallel-out frame register with captured-bit counter.
// frame_next is the frame including the bit being sampled this cycle.
module loader_shifter
  import prog_loader_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         shift_en,
  input  logic         mosi,
  output logic [W-1:0] frame_next,
  output logic         last_bit
);

  // Holds only the W-1 newest bits; the incoming bit completes the window.
  logic [W-2:0]       sr;
  logic [CNT_W-1:0]   count;

  always_comb begin
    frame_next = start ? {mosi, {(W-1){1'b0}}} : {mosi, sr};
  end

  assign last_bit = (count == CNT_W'(W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      count <= '0;
    end else if (start) begin
      sr    <= frame_next[W-1:1];
      count <= CNT_W'(1);
    end else if (shift_en) begin
      sr    <= frame_next[W-1:1];
      count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: writes framed words into the I/D caches, then runs.
// Optional odd-parity bit per frame when PROG_LOADER_PARITY_EN is defined.
module prog_loader #(
  parameter int FRAME_W = prog_loader_pkg::FRAME_W,
  parameter int DATA_W  = prog_loader_pkg::DATA_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                csi_n,
  input  logic                                csd_n,
  input  logic                                mosi,
  input  logic                                proc_en_in,
  output logic [DATA_W-1:0]                   wr_data_out,
  output logic [prog_loader_pkg::ADDR_W-1:0]  wr_addr_out,
  output logic                                icache_wen_out,
  output logic                                dcache_wen_out,
  output logic                                run_out,
  output logic                                busy_out,
  output logic                                frame_err_out
);
  import prog_loader_pkg::*;

`ifdef PROG_LOADER_PARITY_EN
  localparam int SR_W = FRAME_W + 1;
`else
  localparam int SR_W = FRAME_W;
`endif

  state_t            state;
  target_t           target;
  logic              start, shift_en, last_bit, frame_ok;
  logic              one_sel, both_sel, sel_rise;
  logic [SR_W-1:0]   frame_next;

  assign one_sel  = csi_n ^ csd_n;
  assign both_sel = !csi_n && !csd_n;
  assign sel_rise = (target == TGT_I) ? csi_n : csd_n;
  assign start    = (state == ST_IDLE) && one_sel && !proc_en_in;
  assign shift_en = (state == ST_SHIFT) && !sel_rise;

`ifdef PROG_LOADER_PARITY_EN
  // Odd parity: data, address and parity bit together hold an odd count of ones.
  assign frame_ok = ^frame_next;
`else
  assign frame_ok = 1'b1;
`endif

  loader_shifter #(.W(SR_W)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shift_en   (shift_en),
    .mosi       (mosi),
    .frame_next (frame_next),
    .last_bit   (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      target         <= TGT_I;
      wr_data_out    <= '0;
      wr_addr_out    <= '0;
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      run_out        <= 1'b0;
      busy_out       <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      frame_err_out  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (both_sel) begin
            frame_err_out <= 1'b1;
          end else if (proc_en_in) begin
            state   <= ST_RUN;
            run_out <= 1'b1;
          end else if (one_sel) begin
            state    <= ST_SHIFT;
            busy_out <= 1'b1;
            target   <= csi_n ? TGT_D : TGT_I;
          end
        end
        ST_SHIFT: begin
          if (sel_rise || (last_bit && !frame_ok)) begin
            state         <= ST_IDLE;
            busy_out      <= 1'b0;
            frame_err_out <= 1'b1;
          end else if (last_bit) begin
            // Strobe and data leave together on the edge that samples the last bit.
            state          <= ST_COMMIT;
            wr_addr_out    <= frame_next[ADDR_W-1:0];
            wr_data_out    <= frame_next[FRAME_W-1:ADDR_W];
            icache_wen_out <= (target == TGT_I);
            dcache_wen_out <= (target == TGT_D);
          end
        end
        ST_COMMIT: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
        ST_RUN: begin
          if (!proc_en_in) begin
            state   <= ST_IDLE;
            run_out <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a transaction-level model.
module tb_prog_loader;

  localparam int FRAME_W = 12;
  localparam int DATA_W  = 8;
`ifdef PROG_LOADER_PARITY_EN
  localparam int  NB  = FRAME_W + 1;
  localparam bit  PAR = 1'b1;
`else
  localparam int  NB  = FRAME_W;
  localparam bit  PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, csi_n, csd_n, mosi, proc_en_in;
  logic [DATA_W-1:0] wr_data_out;
  logic [3:0]        wr_addr_out;
  logic              icache_wen_out, dcache_wen_out, run_out, busy_out, frame_err_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: last committed word, cleared by reset.
  logic [DATA_W-1:0] exp_data = '0;
  logic [3:0]        exp_addr = '0;

  prog_loader #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .csi_n          (csi_n),
    .csd_n          (csd_n),
    .mosi           (mosi),
    .proc_en_in     (proc_en_in),
    .wr_data_out    (wr_data_out),
    .wr_addr_out    (wr_addr_out),
    .icache_wen_out (icache_wen_out),
    .dcache_wen_out (dcache_wen_out),
    .run_out        (run_out),
    .busy_out       (busy_out),
    .frame_err_out  (frame_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0; proc_en_in = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wen"}, {30'd0, icache_wen_out, dcache_wen_out}, 0);
    check({tag, "_err"}, frame_err_out, 0);
    check({tag, "_data"}, wr_data_out, exp_data);
    check({tag, "_addr"}, wr_addr_out, exp_addr);
  endtask

  function automatic logic [12:0] make_bits(input logic [7:0] data, input logic [3:0] addr,
                                            input bit bad_par);
    logic [12:0] b;
    b = {1'b0, data, addr};
    b[12] = bad_par ? (^b[11:0]) : ~(^b[11:0]);
    return b;
  endfunction

  // Drives n bits LSB-first; noise on the other select and proc_en after bit 0
  // must be ignored while a frame is in flight.
  task automatic send_bits(input bit is_d, input logic [12:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      csi_n = is_d;
      csd_n = !is_d;
      mosi  = bits[i];
      if (i > 0) begin
        proc_en_in = 1'($urandom_range(0, 1));
        if (is_d) csi_n = 1'($urandom_range(0, 1));
        else      csd_n = 1'($urandom_range(0, 1));
      end else begin
        proc_en_in = 1'b0;
      end
      step();
      if (i < NB - 1) begin
        check("mid_busy", busy_out, 1);
        check("mid_run", run_out, 0);
        check_quiet("mid");
      end
    end
  endtask

  // abort_at = 0 sends a full frame; otherwise the select rises after abort_at bits.
  task automatic send_frame(input bit is_d, input logic [7:0] data, input logic [3:0] addr,
                            input int abort_at, input bit bad_par);
    logic [12:0] bits;
    bits = make_bits(data, addr, bad_par);
    send_bits(is_d, bits, (abort_at > 0) ? abort_at : NB);
    idle_inputs();
    if (abort_at > 0) begin
      step();
      check("abort_err", frame_err_out, 1);
      check("abort_wen", {30'd0, icache_wen_out, dcache_wen_out}, 0);
      check("abort_busy", busy_out, 0);
    end else if (bad_par) begin
      check("par_err", frame_err_out, 1);
      check("par_wen", {30'd0, icache_wen_out, dcache_wen_out}, 0);
      check("par_busy", busy_out, 0);
    end else begin
      exp_data = data;
      exp_addr = addr;
      check("commit_iwen", icache_wen_out, !is_d);
      check("commit_dwen", dcache_wen_out, is_d);
      check("commit_data", wr_data_out, exp_data);
      check("commit_addr", wr_addr_out, exp_addr);
      check("commit_busy", busy_out, 1);
      check("commit_err", frame_err_out, 0);
    end
    step();
    check("post_busy", busy_out, 0);
    check_quiet("post");
  endtask

  task automatic run_session(input int cycles, input bit reset_inside);
    proc_en_in = 1'b1; csi_n = 1'b1; csd_n = 1'b1;
    step();
    check("run_on", run_out, 1);
    for (int i = 0; i < cycles; i++) begin
      csi_n = 1'($urandom_range(0, 1));
      csd_n = 1'($urandom_range(0, 1));
      mosi  = 1'($urandom_range(0, 1));
      step();
      check("run_hold", run_out, 1);
      check("run_busy", busy_out, 0);
      check_quiet("run");
    end
    if (reset_inside) begin
      rst = 1'b1; idle_inputs();
      step();
      rst = 1'b0;
      exp_data = '0; exp_addr = '0;
      check("run_rst_run", run_out, 0);
      check_quiet("run_rst");
    end else begin
      idle_inputs();
      step();
      check("run_off", run_out, 0);
      check_quiet("run_off");
    end
  endtask

  task automatic both_low();
    csi_n = 1'b0; csd_n = 1'b0; proc_en_in = 1'($urandom_range(0, 1));
    step();
    check("both_err", frame_err_out, 1);
    check("both_busy", busy_out, 0);
    check("both_run", run_out, 0);
    idle_inputs();
    step();
    check_quiet("both_after");
  endtask

  task automatic reset_mid_frame(input bit is_d, input int nbits);
    logic [12:0] bits;
    bits = make_bits(8'($urandom), 4'($urandom), 1'b0);
    send_bits(is_d, bits, nbits);
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    exp_data = '0; exp_addr = '0;
    check("rst_busy", busy_out, 0);
    check("rst_run", run_out, 0);
    check_quiet("rst");
    step();
    check("rst_after_busy", busy_out, 0);
    check_quiet("rst_after");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("reset_run", run_out, 0);
    check("reset_busy", busy_out, 0);
    check_quiet("reset");
    rst = 1'b0;
    step();

    // Directed scenarios.
    send_frame(1'b0, 8'hA5, 4'h3, 0, 1'b0);
    send_frame(1'b1, 8'hFF, 4'hE, 0, 1'b0);
    send_frame(1'b0, 8'h5A, 4'h7, 7, 1'b0);
    send_frame(1'b0, 8'h3C, 4'h1, 0, 1'b0);
    send_frame(1'b1, 8'h01, 4'h0, 1, 1'b0);
    send_frame(1'b1, 8'h80, 4'hF, NB - 1, 1'b0);
    run_session(4, 1'b0);
    both_low();
    send_frame(1'b0, 8'h66, 4'h9, 0, 1'b0);
    reset_mid_frame(1'b0, 9);
    if (PAR) begin
      send_frame(1'b0, 8'hC3, 4'h2, 0, 1'b1);
      send_frame(1'b0, 8'hC3, 4'h2, 0, 1'b0);
    end

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      int  kind;
      bit  is_d;
      kind = $urandom_range(0, 6);
      is_d = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2: send_frame(is_d, 8'($urandom), 4'($urandom), 0, PAR && ($urandom_range(0, 3) == 0));
        3:       send_frame(is_d, 8'($urandom), 4'($urandom), $urandom_range(1, NB - 1), 1'b0);
        4:       run_session($urandom_range(0, 6), $urandom_range(0, 3) == 0);
        5:       both_low();
        default: reset_mid_frame(is_d, $urandom_range(1, NB - 1));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
